// File: rtl/shadow_stack_ctrl.sv
// Shadow-stack sequencing controller: owns the shadow-stack pointer and runs
// push / pop-check / read-ssp / write-ssp operations over a req/gnt memory port.
module shadow_stack_ctrl #(
    parameter int               XLEN      = 64,
    parameter logic [XLEN-1:0]  SSP_RESET = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            xsse_i,
    input  logic            flush_i,
    input  logic            op_valid_i,
    output logic            op_ready_o,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] data_i,
    output logic            result_valid_o,
    output logic [XLEN-1:0] result_o,
    output logic            fault_o,
    output logic [1:0]      fault_cause_o,
    output logic [XLEN-1:0] ssp_o,
    output logic            mem_req_o,
    input  logic            mem_gnt_i,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic            mem_err_i
);

    localparam int              SLOT       = XLEN / 8;
    localparam logic [XLEN-1:0] SLOT_BYTES = XLEN'(SLOT);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(SLOT - 1));
    localparam logic [1:0]      CAUSE_NONE     = 2'b00;
    localparam logic [1:0]      CAUSE_MISMATCH = 2'b01;
    localparam logic [1:0]      CAUSE_ACCESS   = 2'b10;

    typedef enum logic [1:0] {
        OP_PUSH   = 2'b00,
        OP_POPCHK = 2'b01,
        OP_WRSSP  = 2'b10,
        OP_RDSSP  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        ST_REQ,
        LD_REQ,
        LD_WAIT,
        DRAIN,
        RESP
    } state_e;

    state_e          state_reg,  state_next;
    logic [XLEN-1:0] ssp_reg,    ssp_next;
    logic [XLEN-1:0] data_reg,   data_next;
    logic [XLEN-1:0] result_reg, result_next;
    logic            fault_reg,  fault_next;
    logic [1:0]      cause_reg,  cause_next;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg  <= IDLE;
            ssp_reg    <= SSP_RESET & ALIGN_MASK;
            data_reg   <= '0;
            result_reg <= '0;
            fault_reg  <= 1'b0;
            cause_reg  <= CAUSE_NONE;
        end else begin
            state_reg  <= state_next;
            ssp_reg    <= ssp_next;
            data_reg   <= data_next;
            result_reg <= result_next;
            fault_reg  <= fault_next;
            cause_reg  <= cause_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        ssp_next    = ssp_reg;
        data_next   = data_reg;
        result_next = result_reg;
        fault_next  = fault_reg;
        cause_next  = cause_reg;

        case (state_reg)
            IDLE: begin
                if (op_valid_i && !flush_i) begin
                    data_next   = data_i;
                    result_next = '0;
                    fault_next  = 1'b0;
                    cause_next  = CAUSE_NONE;
                    state_next  = RESP;
                    case (op_e'(op_i))
                        OP_PUSH:   if (xsse_i) state_next = ST_REQ;
                        OP_POPCHK: if (xsse_i) state_next = LD_REQ;
                        OP_WRSSP:  ssp_next = data_i & ALIGN_MASK;
                        OP_RDSSP:  result_next = xsse_i ? ssp_reg : '0;
                        default:   state_next = RESP;
                    endcase
                end
            end
            ST_REQ: begin
                // A granted store is architecturally done even if flushed.
                if (mem_gnt_i) begin
                    ssp_next   = ssp_reg - SLOT_BYTES;
                    state_next = flush_i ? IDLE : RESP;
                end else if (flush_i) begin
                    state_next = IDLE;
                end
            end
            LD_REQ: begin
                if (mem_gnt_i) begin
                    state_next = flush_i ? DRAIN : LD_WAIT;
                end else if (flush_i) begin
                    state_next = IDLE;
                end
            end
            LD_WAIT: begin
                if (flush_i) begin
                    // A response arriving with the flush is consumed right here.
                    state_next = mem_rvalid_i ? IDLE : DRAIN;
                end else if (mem_rvalid_i) begin
                    state_next = RESP;
                    if (mem_err_i) begin
                        fault_next = 1'b1;
                        cause_next = CAUSE_ACCESS;
                    end else if (mem_rdata_i != data_reg) begin
                        fault_next = 1'b1;
                        cause_next = CAUSE_MISMATCH;
                    end else begin
                        ssp_next = ssp_reg + SLOT_BYTES;
                    end
                end
            end
            DRAIN: begin
                if (mem_rvalid_i) state_next = IDLE;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    logic resp_fire;
    assign resp_fire = (state_reg == RESP) && !flush_i;

    assign op_ready_o     = (state_reg == IDLE) && !flush_i;
    assign result_valid_o = resp_fire;
    assign result_o       = resp_fire ? result_reg : '0;
    assign fault_o        = resp_fire && fault_reg;
    assign fault_cause_o  = resp_fire ? cause_reg : CAUSE_NONE;
    assign ssp_o          = ssp_reg;

    assign mem_req_o   = (state_reg == ST_REQ) || (state_reg == LD_REQ);
    assign mem_we_o    = (state_reg == ST_REQ);
    assign mem_addr_o  = (state_reg == ST_REQ) ? (ssp_reg - SLOT_BYTES) :
                         (state_reg == LD_REQ) ? ssp_reg : '0;
    assign mem_wdata_o = (state_reg == ST_REQ) ? data_reg : '0;

endmodule

// File: tb/tb_shadow_stack_ctrl.sv
// Directed bench for shadow_stack_ctrl: a vector table of complete operations
// followed by hand-written flush and reset sequences.
module tb_shadow_stack_ctrl;

    localparam logic [1:0] PUSH   = 2'b00;
    localparam logic [1:0] POPCHK = 2'b01;
    localparam logic [1:0] WRSSP  = 2'b10;
    localparam logic [1:0] RDSSP  = 2'b11;
    localparam logic [63:0] RST_SSP = 64'h8000_1000;

    logic        clk = 1'b0;
    logic        rst, xsse, flush, op_valid, op_ready;
    logic [1:0]  op;
    logic [63:0] data, result, ssp, mem_addr, mem_wdata, mem_rdata;
    logic        result_valid, fault, mem_req, mem_gnt, mem_we, mem_rvalid, mem_err;
    logic [1:0]  fault_cause;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    shadow_stack_ctrl #(.XLEN(64), .SSP_RESET(RST_SSP)) dut (
        .clk_i(clk), .rst_i(rst), .xsse_i(xsse), .flush_i(flush),
        .op_valid_i(op_valid), .op_ready_o(op_ready), .op_i(op), .data_i(data),
        .result_valid_o(result_valid), .result_o(result), .fault_o(fault),
        .fault_cause_o(fault_cause), .ssp_o(ssp),
        .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err)
    );

    typedef struct {
        logic [1:0]  op;
        logic        xsse;
        logic [63:0] data;
        int          gnt_dly;
        int          rv_dly;
        logic [63:0] rdata;
        logic        err;
        logic [63:0] exp_addr;
        logic [63:0] exp_result;
        logic        exp_fault;
        logic [1:0]  exp_cause;
        logic [63:0] exp_ssp;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic accept(input logic [1:0] o, input logic [63:0] d, input logic x);
        @(negedge clk);
        op_valid = 1'b1; op = o; data = d; xsse = x;
        check("op_ready_at_accept", op_ready, 1);
        @(posedge clk);
        #1 op_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit is_mem;
        is_mem = v.xsse && (v.op == PUSH || v.op == POPCHK);
        accept(v.op, v.data, v.xsse);
        if (is_mem) begin
            for (int k = 0; k < v.gnt_dly; k++) begin
                @(negedge clk);
                check("req_held", mem_req, 1);
                check("addr_held", mem_addr, v.exp_addr);
                @(posedge clk);
            end
            @(negedge clk);
            check("req", mem_req, 1);
            check("we", mem_we, (v.op == PUSH) ? 1 : 0);
            check("addr", mem_addr, v.exp_addr);
            if (v.op == PUSH) check("wdata", mem_wdata, v.data);
            mem_gnt = 1'b1;
            @(posedge clk);
            #1 mem_gnt = 1'b0;
            if (v.op == POPCHK) begin
                for (int k = 0; k < v.rv_dly; k++) begin
                    @(negedge clk);
                    check("req_dropped_in_wait", mem_req, 0);
                    @(posedge clk);
                end
                @(negedge clk);
                mem_rvalid = 1'b1; mem_rdata = v.rdata; mem_err = v.err;
                @(posedge clk);
                #1 mem_rvalid = 1'b0; mem_err = 1'b0;
            end
        end
        @(negedge clk);
        check("result_valid", result_valid, 1);
        check("result", result, v.exp_result);
        check("fault", fault, v.exp_fault);
        check("fault_cause", fault_cause, v.exp_cause);
        check("ssp", ssp, v.exp_ssp);
        check("no_req_in_resp", mem_req, 0);
        $display("vec %0d op=%0d xsse=%0d data=%h -> result=%h fault=%0d cause=%0d ssp=%h",
                 idx, v.op, v.xsse, v.data, result, fault, fault_cause, ssp);
        @(posedge clk);
        @(negedge clk);
        check("result_pulse_one_cycle", result_valid, 0);
    endtask

    function automatic vec_t mk(input logic [1:0] o, input logic x, input logic [63:0] d,
                                input int gd, input int rd, input logic [63:0] rdat,
                                input logic e, input logic [63:0] addr, input logic [63:0] res,
                                input logic f, input logic [1:0] c, input logic [63:0] s);
        vec_t v;
        v.op = o; v.xsse = x; v.data = d; v.gnt_dly = gd; v.rv_dly = rd;
        v.rdata = rdat; v.err = e; v.exp_addr = addr; v.exp_result = res;
        v.exp_fault = f; v.exp_cause = c; v.exp_ssp = s;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(WRSSP,  1, 64'h8000_2007, 0, 0, 0, 0, 0, 0, 0, 2'b00, 64'h8000_2000);
        vecs[1]  = mk(WRSSP,  1, 64'h8000_1000, 0, 0, 0, 0, 0, 0, 0, 2'b00, 64'h8000_1000);
        vecs[2]  = mk(PUSH,   1, 64'hDEAD_BEEF, 2, 0, 0, 0, 64'h8000_0FF8, 0, 0, 2'b00, 64'h8000_0FF8);
        vecs[3]  = mk(RDSSP,  1, 64'h0, 0, 0, 0, 0, 0, 64'h8000_0FF8, 0, 2'b00, 64'h8000_0FF8);
        vecs[4]  = mk(POPCHK, 1, 64'hDEAD_BEEF, 0, 0, 64'hDEAD_BEEF, 0, 64'h8000_0FF8, 0, 0, 2'b00, 64'h8000_1000);
        vecs[5]  = mk(PUSH,   1, 64'hDEAD_BEEF, 0, 0, 0, 0, 64'h8000_0FF8, 0, 0, 2'b00, 64'h8000_0FF8);
        vecs[6]  = mk(POPCHK, 1, 64'hDEAD_BEEF, 1, 2, 64'hDEAD_BEEE, 0, 64'h8000_0FF8, 0, 1, 2'b01, 64'h8000_0FF8);
        vecs[7]  = mk(POPCHK, 1, 64'hDEAD_BEEF, 0, 1, 64'hDEAD_BEEF, 1, 64'h8000_0FF8, 0, 1, 2'b10, 64'h8000_0FF8);
        vecs[8]  = mk(PUSH,   0, 64'h1111_2222, 0, 0, 0, 0, 0, 0, 0, 2'b00, 64'h8000_0FF8);
        vecs[9]  = mk(RDSSP,  0, 64'h0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 64'h8000_0FF8);
        vecs[10] = mk(POPCHK, 0, 64'h3333, 0, 0, 0, 0, 0, 0, 0, 2'b00, 64'h8000_0FF8);
        vecs[11] = mk(WRSSP,  0, 64'h0000_0000_0000_0005, 0, 0, 0, 0, 0, 0, 0, 2'b00, 64'h0);
        vecs[12] = mk(PUSH,   1, 64'h1234, 1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 2'b00, 64'hFFFF_FFFF_FFFF_FFF8);
        vecs[13] = mk(POPCHK, 1, 64'h1234, 0, 0, 64'h1234, 0, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 2'b00, 64'h0);
        vecs[14] = mk(WRSSP,  1, 64'h8000_1000, 0, 0, 0, 0, 0, 0, 0, 2'b00, 64'h8000_1000);

        rst = 1'b1; xsse = 1'b0; flush = 1'b0; op_valid = 1'b0; op = 2'b00; data = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_ssp", ssp, RST_SSP);
        check("reset_op_ready", op_ready, 1);
        check("reset_mem_req", mem_req, 0);
        check("reset_result_valid", result_valid, 0);
        check("reset_fault", fault, 0);

        for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

        // Grant and flush together on a push: pointer still moves, no result.
        accept(PUSH, 64'hCAFE, 1'b1);
        @(negedge clk);
        mem_gnt = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 mem_gnt = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("gnt_flush_ssp", ssp, 64'h8000_0FF8);
        check("gnt_flush_no_result", result_valid, 0);
        check("gnt_flush_idle", op_ready, 1);
        $display("seq push gnt+flush ssp=%h", ssp);

        // Flush during the response cycle hides the pulse.
        accept(RDSSP, 64'h0, 1'b1);
        @(negedge clk);
        flush = 1'b1;
        #1 check("resp_flush_no_pulse", result_valid, 0);
        @(posedge clk);
        #1 flush = 1'b0;
        $display("seq flush in RESP result_valid=%0d", result_valid);

        // Flush in LD_WAIT, response arrives 3 cycles later and is discarded.
        accept(POPCHK, 64'hAAAA, 1'b1);
        @(negedge clk);
        check("pop_req", mem_req, 1);
        mem_gnt = 1'b1;
        @(posedge clk);
        #1 mem_gnt = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("drain_not_ready", op_ready, 0);
            check("drain_no_result", result_valid, 0);
            @(posedge clk);
        end
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 64'h5555;
        check("drain_not_ready_rvalid", op_ready, 0);
        @(posedge clk);
        #1 mem_rvalid = 1'b0;
        @(negedge clk);
        check("drain_done_ready", op_ready, 1);
        check("drain_no_result_after", result_valid, 0);
        check("drain_no_fault", fault, 0);
        check("drain_ssp", ssp, 64'h8000_0FF8);
        $display("seq flush in LD_WAIT ssp=%h ready=%0d", ssp, op_ready);

        // Flush in ST_REQ without grant drops the store.
        accept(PUSH, 64'hBEEF, 1'b1);
        @(negedge clk);
        check("st_req_pending", mem_req, 1);
        flush = 1'b1;
        #1 check("flush_blocks_ready", op_ready, 0);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("st_flush_req", mem_req, 0);
        check("st_flush_result", result_valid, 0);
        check("st_flush_ssp", ssp, 64'h8000_0FF8);
        check("st_flush_ready", op_ready, 1);
        $display("seq flush in ST_REQ ssp=%h", ssp);

        // Reset while a store request is pending.
        accept(PUSH, 64'h7777, 1'b1);
        @(negedge clk);
        check("rst_seq_req", mem_req, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_req", mem_req, 0);
        check("rst_mid_ssp", ssp, RST_SSP);
        check("rst_mid_ready", op_ready, 1);
        mem_rvalid = 1'b1; mem_rdata = 64'h7777;
        @(posedge clk);
        #1 mem_rvalid = 1'b0;
        @(negedge clk);
        check("stray_rvalid_no_result", result_valid, 0);
        check("stray_rvalid_ssp", ssp, RST_SSP);
        $display("seq reset in ST_REQ ssp=%h req=%0d", ssp, mem_req);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
